// File: rtl/game_pkg.sv
// Shared game constants: grid positions, spawner states, score limits.
package game_pkg;

  localparam int unsigned POS_W   = 4;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned LFSR_W  = 16;

  // Grid positions: 0 = empty, 1..9 = keys Q,W,E,A,S,D,Z,X,C
  localparam logic [POS_W-1:0] POS_NONE = 4'd0;
  localparam logic [POS_W-1:0] POS_Q    = 4'd1;
  localparam logic [POS_W-1:0] POS_W_   = 4'd2;
  localparam logic [POS_W-1:0] POS_E    = 4'd3;
  localparam logic [POS_W-1:0] POS_A    = 4'd4;
  localparam logic [POS_W-1:0] POS_S    = 4'd5;
  localparam logic [POS_W-1:0] POS_D    = 4'd6;
  localparam logic [POS_W-1:0] POS_Z    = 4'd7;
  localparam logic [POS_W-1:0] POS_X    = 4'd8;
  localparam logic [POS_W-1:0] POS_C    = 4'd9;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } spawner_state_e;

  // Map a grid index 0..8 onto its position code
  function automatic logic [POS_W-1:0] pos_from_index(input logic [3:0] idx);
    logic [POS_W-1:0] p;
    p = POS_NONE;
    case (idx)
      4'd0:    p = POS_Q;
      4'd1:    p = POS_W_;
      4'd2:    p = POS_E;
      4'd3:    p = POS_A;
      4'd4:    p = POS_S;
      4'd5:    p = POS_D;
      4'd6:    p = POS_Z;
      4'd7:    p = POS_X;
      4'd8:    p = POS_C;
      default: p = POS_NONE;
    endcase
    return p;
  endfunction

  // Next position in cyclic order 1..9 (C wraps to Q)
  function automatic logic [POS_W-1:0] pos_after(input logic [POS_W-1:0] p);
    return (p == POS_C) ? POS_Q : POS_W'(p + 4'd1);
  endfunction

  // Spawn candidate: (rnd mod 9)+1, bumped one step if it repeats the last enemy
  function automatic logic [POS_W-1:0] pick_pos(input logic [3:0]       rnd,
                                                input logic [POS_W-1:0] last);
    logic [3:0]       idx;
    logic [POS_W-1:0] c;
    idx = (rnd >= 4'd9) ? 4'(rnd - 4'd9) : rnd;
    c   = pos_from_index(idx);
    if (c == last) begin
      c = pos_after(c);
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Advance every cycle; reload seed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/enemy_spawner.sv
// Enemy spawner: places an enemy on the 3x3 grid for a fixed lifetime,
// judges keypresses against it and keeps a saturating hit score.
module enemy_spawner
  import game_pkg::*;
#(
  parameter int unsigned       LIFE_CYCLES = 50_000_000,
  parameter int unsigned       GAP_CYCLES  = 25_000_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               key_valid,
  input  logic [POS_W-1:0]   key_pos,
  output logic [POS_W-1:0]   pos,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score
);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIFE_LAST = CNT_W'(LIFE_CYCLES - 1);

  spawner_state_e     r_state;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   r_last_pos;
  logic               r_hit;
  logic               r_miss;
  logic [SCORE_W-1:0] r_score;
  logic [CNT_W-1:0]   r_cnt;

  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_unused_lfsr_hi;
  logic [POS_W-1:0]   w_cand;
  logic               w_key_match;
  logic               w_gap_done;
  logic               w_life_done;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Only the low nibble feeds position selection
  assign w_unused_lfsr_hi = ^w_lfsr[LFSR_W-1:4];

  assign w_cand      = pick_pos(w_lfsr[3:0], r_last_pos);
  assign w_key_match = (r_state == SHOW) && key_valid && (key_pos == r_pos)
                       && (r_pos != POS_NONE);
  assign w_gap_done  = (r_cnt == GAP_LAST);
  assign w_life_done = (r_cnt == LIFE_LAST);

  // Round FSM with registered position, pulses and score
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pos      <= POS_NONE;
      r_last_pos <= POS_NONE;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_score    <= '0;
      r_cnt      <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (!enable) begin
        // Round aborted: clear the grid silently, keep the score on display
        r_state <= IDLE;
        r_pos   <= POS_NONE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_score <= '0;
            r_cnt   <= '0;
            r_pos   <= POS_NONE;
            r_state <= GAP;
          end
          GAP: begin
            if (w_gap_done) begin
              r_pos      <= w_cand;
              r_last_pos <= w_cand;
              r_cnt      <= '0;
              r_state    <= SHOW;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          SHOW: begin
            // A whack on the final visible cycle still counts as a hit
            if (w_key_match) begin
              r_hit   <= 1'b1;
              r_pos   <= POS_NONE;
              r_cnt   <= '0;
              r_state <= GAP;
              if (r_score != SCORE_MAX) begin
                r_score <= r_score + SCORE_W'(1);
              end
            end else if (w_life_done) begin
              r_miss  <= 1'b1;
              r_pos   <= POS_NONE;
              r_cnt   <= '0;
              r_state <= GAP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_pos   <= POS_NONE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign pos   = r_pos;
  assign hit   = r_hit;
  assign miss  = r_miss;
  assign score = r_score;

endmodule

// File: tb/tb_enemy_spawner.sv
// Self-checking bench for enemy_spawner with short lifetime/gap parameters.
module tb_enemy_spawner;

  localparam int unsigned LIFE  = 8;
  localparam int unsigned GAP   = 4;
  localparam int          BOUND = 64;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       key_valid;
  logic [3:0] key_pos;
  logic [3:0] pos;
  logic       hit;
  logic       miss;
  logic [7:0] score;

  int         n_vec = 0;
  int         n_err = 0;
  int         exp_score = 0;
  int         prev_pos = 0;
  int         ref_lfsr = int'(SEED);
  int         ref_lfsr_before = int'(SEED);

  always #5 clk = ~clk;

  enemy_spawner #(
    .LIFE_CYCLES (LIFE),
    .GAP_CYCLES  (GAP),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .key_valid (key_valid),
    .key_pos   (key_pos),
    .pos       (pos),
    .hit       (hit),
    .miss      (miss),
    .score     (score)
  );

  // Reference random source: polynomial x^16+x^14+x^13+x^11+1, one step per clock
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_lfsr        = int'(SEED);
      ref_lfsr_before = int'(SEED);
    end else begin
      ref_lfsr_before = ref_lfsr;
      ref_lfsr = ((ref_lfsr << 1) |
                  (((ref_lfsr >> 15) ^ (ref_lfsr >> 13) ^
                    (ref_lfsr >> 12) ^ (ref_lfsr >> 10)) & 1)) & 32'hFFFF;
    end
  end

  // Spawn rule applied to the random value seen at the spawning edge
  function automatic int expected_spawn(input int rnd, input int last);
    int c;
    c = ((rnd % 16) % 9) + 1;
    if (c == last) c = (c % 9) + 1;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk through empty-grid cycles pressing random keys; report run length and late pulses
  task automatic wait_spawn(output int zeros, output int stray, output int exp_p);
    zeros = 0;
    stray = 0;
    exp_p = 0;
    while (pos == 4'd0 && zeros < BOUND) begin
      if (zeros > 0 && (hit || miss)) stray++;
      key_valid = 1'($urandom_range(0, 1));
      key_pos   = 4'($urandom_range(0, 15));
      zeros++;
      step();
    end
    key_valid = 1'b0;
    exp_p = expected_spawn(ref_lfsr_before, prev_pos);
  endtask

  task automatic check_spawn(input string name, input int zeros, input int stray, input int exp_p);
    n_vec++;
    if (zeros != int'(GAP) || stray != 0) begin
      n_err++;
      $display("FAIL %s_gap: got %0d empty cycles (%0d stray pulses), expected %0d and 0",
               name, zeros, stray, GAP);
    end
    n_vec++;
    if (int'(pos) != exp_p || exp_p == prev_pos) begin
      n_err++;
      $display("FAIL %s_pos: got pos %0d, expected %0d (previous %0d)", name, pos, exp_p, prev_pos);
    end
    prev_pos = int'(pos);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; key_valid = 1'b0; key_pos = 4'd0;
    #12;
    n_vec++;
    if (pos !== 4'd0 || hit !== 1'b0 || miss !== 1'b0 || score !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got pos=%0d hit=%0b miss=%0b score=%0d, expected all 0",
               pos, hit, miss, score);
    end
    step();
    rst = 1'b0;
    step(); step();
    n_vec++;
    if (pos !== 4'd0 || score !== 8'd0) begin
      n_err++;
      $display("FAIL idle_hold: got pos=%0d score=%0d, expected 0 0", pos, score);
    end
  endtask

  task automatic test_timeout();
    int z, s, e, life;
    logic [3:0] p;
    enable = 1'b1;
    step();
    wait_spawn(z, s, e);
    check_spawn("timeout", z, s, e);
    p = pos; life = 0;
    while (pos == p && life < BOUND) begin
      life++;
      step();
    end
    n_vec++;
    if (life != int'(LIFE)) begin
      n_err++;
      $display("FAIL timeout_life: got %0d visible cycles, expected %0d", life, LIFE);
    end
    n_vec++;
    if (pos !== 4'd0 || miss !== 1'b1 || hit !== 1'b0 || score !== 8'd0) begin
      n_err++;
      $display("FAIL timeout_miss: got pos=%0d miss=%0b hit=%0b score=%0d, expected 0 1 0 0",
               pos, miss, hit, score);
    end
  endtask

  task automatic test_hit();
    int z, s, e;
    logic [3:0] p;
    wait_spawn(z, s, e);
    check_spawn("hit", z, s, e);
    p = pos;
    step(); step();
    n_vec++;
    if (pos !== p) begin
      n_err++;
      $display("FAIL hit_hold: got pos=%0d, expected %0d", pos, p);
    end
    key_valid = 1'b1; key_pos = p;
    step();
    key_valid = 1'b0;
    exp_score++;
    n_vec++;
    if (hit !== 1'b1 || miss !== 1'b0 || pos !== 4'd0 || int'(score) != exp_score) begin
      n_err++;
      $display("FAIL hit_pulse: got hit=%0b miss=%0b pos=%0d score=%0d, expected 1 0 0 %0d",
               hit, miss, pos, score, exp_score);
    end
    wait_spawn(z, s, e);
    check_spawn("after_hit", z, s, e);
  endtask

  task automatic test_wrong_key_and_terminal_hit();
    int z, s, e, life;
    logic [3:0] p;
    p = pos; life = 0;
    while (pos == p && life < BOUND) begin
      life++;
      if (life == 3) begin
        key_valid = 1'b1;
        key_pos   = (p == 4'd9) ? 4'd1 : 4'(p + 4'd1);
      end else begin
        key_valid = 1'b0;
      end
      step();
    end
    key_valid = 1'b0;
    n_vec++;
    if (life != int'(LIFE) || miss !== 1'b1 || hit !== 1'b0 || int'(score) != exp_score) begin
      n_err++;
      $display("FAIL wrong_key: got life=%0d miss=%0b hit=%0b score=%0d, expected %0d 1 0 %0d",
               life, miss, hit, score, LIFE, exp_score);
    end
    wait_spawn(z, s, e);
    check_spawn("terminal", z, s, e);
    p = pos; life = 0;
    while (pos == p && life < BOUND) begin
      life++;
      if (life == int'(LIFE)) begin
        key_valid = 1'b1; key_pos = p;
      end else begin
        key_valid = 1'b0;
      end
      step();
    end
    key_valid = 1'b0;
    exp_score++;
    n_vec++;
    if (life != int'(LIFE) || hit !== 1'b1 || miss !== 1'b0 || int'(score) != exp_score) begin
      n_err++;
      $display("FAIL terminal_hit: got life=%0d hit=%0b miss=%0b score=%0d, expected %0d 1 0 %0d",
               life, hit, miss, score, LIFE, exp_score);
    end
  endtask

  task automatic test_random_spawns();
    int z, s, e, d, v;
    logic [3:0] p;
    bit seen [1:9];
    int n_seen;
    for (int i = 1; i <= 9; i++) seen[i] = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      wait_spawn(z, s, e);
      check_spawn("random", z, s, e);
      p = pos;
      if (p >= 4'd1 && p <= 4'd9) seen[int'(p)] = 1'b1;
      d = int'($urandom_range(0, LIFE - 1));
      for (int k = 0; k < d; k++) begin
        v = int'($urandom_range(0, 15));
        if (v == int'(p)) v = 0;
        key_valid = 1'($urandom_range(0, 1));
        key_pos   = 4'(v);
        step();
      end
      key_valid = 1'b1; key_pos = p;
      step();
      key_valid = 1'b0;
      if (exp_score < 255) exp_score++;
      n_vec++;
      if (hit !== 1'b1 || miss !== 1'b0 || pos !== 4'd0 || int'(score) != exp_score) begin
        n_err++;
        $display("FAIL random_hit %0d: got hit=%0b miss=%0b pos=%0d score=%0d, expected 1 0 0 %0d",
                 n, hit, miss, pos, score, exp_score);
      end
    end
    n_seen = 0;
    for (int i = 1; i <= 9; i++) if (seen[i]) n_seen++;
    n_vec++;
    if (n_seen != 9) begin
      n_err++;
      $display("FAIL coverage_all_positions: got %0d distinct positions, expected 9", n_seen);
    end
    n_vec++;
    if (score !== 8'd255) begin
      n_err++;
      $display("FAIL score_saturate: got %0d, expected 255", score);
    end
  endtask

  task automatic test_reset_enable();
    int z, s, e;
    wait_spawn(z, s, e);
    check_spawn("pre_reset", z, s, e);
    step();
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (pos !== 4'd0 || score !== 8'd0 || hit !== 1'b0 || miss !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got pos=%0d score=%0d hit=%0b miss=%0b, expected all 0",
               pos, score, hit, miss);
    end
    exp_score = 0;
    prev_pos  = 0;
    #2 rst = 1'b0;
    step();
    wait_spawn(z, s, e);
    check_spawn("post_reset", z, s, e);
    key_valid = 1'b1; key_pos = pos;
    step();
    key_valid = 1'b0;
    exp_score = 1;
    n_vec++;
    if (hit !== 1'b1 || int'(score) != exp_score) begin
      n_err++;
      $display("FAIL post_reset_hit: got hit=%0b score=%0d, expected 1 %0d", hit, score, exp_score);
    end
    wait_spawn(z, s, e);
    check_spawn("pre_disable", z, s, e);
    step();
    enable = 1'b0;
    step();
    n_vec++;
    if (pos !== 4'd0 || hit !== 1'b0 || miss !== 1'b0 || int'(score) != exp_score) begin
      n_err++;
      $display("FAIL disable: got pos=%0d hit=%0b miss=%0b score=%0d, expected 0 0 0 %0d",
               pos, hit, miss, score, exp_score);
    end
    for (int k = 0; k < 12; k++) begin
      key_valid = 1'($urandom_range(0, 1));
      key_pos   = 4'($urandom_range(0, 15));
      step();
      n_vec++;
      if (pos !== 4'd0 || hit !== 1'b0 || miss !== 1'b0 || int'(score) != exp_score) begin
        n_err++;
        $display("FAIL idle_quiet %0d: got pos=%0d hit=%0b miss=%0b score=%0d, expected 0 0 0 %0d",
                 k, pos, hit, miss, score, exp_score);
      end
    end
    key_valid = 1'b0;
    enable = 1'b1;
    step();
    exp_score = 0;
    n_vec++;
    if (pos !== 4'd0 || score !== 8'd0) begin
      n_err++;
      $display("FAIL round_restart: got pos=%0d score=%0d, expected 0 0", pos, score);
    end
    wait_spawn(z, s, e);
    check_spawn("restart", z, s, e);
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_hit();
    test_wrong_key_and_terminal_hit();
    test_random_spawns();
    test_reset_enable();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enemy_spawner.md
Name: enemy_spawner

Overview:
Game-control stage directly upstream of the enemy sprite renderer: decides where and when an enemy appears on the 3x3 grid. Drives `pos` (0 = no enemy, 1..9 = Q,W,E,A,S,D,Z,X,C) and keeps it stable for a fixed lifetime or until the player whacks it. It judges keypresses against the current position and emits hit/miss pulses plus a saturating score for the HUD.

Parameters:
LIFE_CYCLES, 50_000_000, clk cycles an enemy stays visible (0.5 s at 100 MHz); must be >= 2
GAP_CYCLES, 25_000_000, clk cycles with no enemy between spawns; must be >= 1
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = round running, 0 = idle
key_valid  in  1  one-cycle pulse, a grid key was pressed
key_pos  in  4  grid key code 1..9, qualified by key_valid
pos  out  4  current enemy position, 0 = none; consumed by sprite renderer
hit  out  1  one-cycle pulse, enemy whacked
miss  out  1  one-cycle pulse, enemy timed out
score  out  8  hits this round, saturates at 255

Behaviour:
- Interface: one clock `clk`; `rst` asynchronous, active-high. All outputs registered.
- Reset: state IDLE; pos=0, hit=0, miss=0, score=0, last_pos=0, counter=0, lfsr=LFSR_SEED. Applies immediately, including mid-SHOW.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every clk cycle in every state.
- Candidate position: c = (lfsr[3:0] mod 9) + 1. If c == last_pos, use (c mod 9) + 1. Result is always 1..9 and never equals the previous enemy.
- States: IDLE, GAP, SHOW.
- IDLE: pos=0. When enable=1: next cycle score=0, counter=0, go to GAP.
- GAP: pos=0; counter increments each cycle. When counter==GAP_CYCLES-1: pos<=candidate, last_pos<=candidate, counter<=0, go to SHOW. pos is 0 for exactly GAP_CYCLES cycles.
- SHOW: pos held constant; counter increments each cycle.
  - key_valid=1 and key_pos==pos: next cycle hit=1, pos=0, score+1 (saturating at 255), counter=0, go to GAP.
  - Otherwise, when counter==LIFE_CYCLES-1: next cycle miss=1, pos=0, counter=0, go to GAP. With no hit, pos is nonzero for exactly LIFE_CYCLES cycles.
  - Hit and terminal count in the same cycle: hit wins, no miss.
  - Wrong key, or any key outside SHOW: ignored, no effect.
  - key_pos 0 or >9: never matches.
- hit and miss: single-cycle, mutually exclusive; each coincides with the first cycle pos returns to 0.
- enable=0 in any state: next cycle go to IDLE, pos=0, counter=0, no hit/miss pulse. score holds until the next round start.
- Counters: 32 bits, compared against parameter-1. No wrap occurs within legal parameter values.

Decomposition:
- Shared package (game_pkg):
  - POS_NONE=0, POS_Q=1 .. POS_C=9
  - Spawner state enum {IDLE, GAP, SHOW}
  - SCORE_MAX=255
- Renderer and keyboard decoder use the same POS_* constants.
- Sub-module: lfsr16 (clk, rst, seed parameter, 16-bit out, free-running). Candidate selection stays in enemy_spawner.

Test Plan:
- Timeout, LIFE_CYCLES=8, GAP_CYCLES=4, no keys: raise enable. Expect pos=0 for 4 cycles after the IDLE->GAP cycle, then pos in 1..9 for exactly 8 cycles, then miss=1 for 1 cycle with pos=0; score stays 0.
- Hit: during SHOW cycle 3, pulse key_valid with key_pos==pos. Next cycle hit=1, pos=0, score=1; next enemy appears after exactly 4 zero cycles.
- Wrong key plus simultaneous event: key_pos = pos+1 (mod range) mid-SHOW is ignored and a miss follows. A correct key on the terminal-count cycle gives hit=1 and no miss.
- Randomness: run 1000 spawns with key hits. Every pos is in 1..9, consecutive spawns differ, all 9 values occur. After 300 hits score reads 255.
- Reset/enable: assert rst asynchronously mid-SHOW, so pos=0 and score=0 without a clock edge. Drop enable mid-SHOW: next cycle pos=0, no pulses, state IDLE, score held.
